pwm_multicanal: RTL and testbench

Multi-channel PWM generator and parametrised successor of pwm_basico. A single shared time base has a configurable resolution R and a clock prescaler N, and drives CH independent comparator channels. Each channel has a double-buffered duty register that updates glitch-free at period boundaries. Edge-aligned and center-aligned counting modes are selectable at runtime. The block sits between the register/control logic (duty writes) and the output pins (motor drivers, LEDs, servos).

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_multicanal_if.sv | 30 +++
 rtl/pwm_base_tiempo.sv | 82 ++++++++
 rtl/pwm_multicanal.sv | 75 +++++++
 tb/tb_pwm_multicanal.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam logic MODO_BORDE  = 1'b0;
  localparam logic MODO_CENTRO = 1'b1;

  typedef enum logic {
    SUBE = 1'b0,
    BAJA = 1'b1
  } dir_e;

  // Width of the channel-select field: clog2 with a floor of one bit.
  function automatic int ancho_ch(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_multicanal_if.sv
// Control/duty-write and PWM-output bundle between register logic and pwm_multicanal.
interface pwm_multicanal_if
  import pwm_pkg::*;
#(
  parameter int R  = 8,
  parameter int CH = 4
) ();

  localparam int WCH = ancho_ch(CH);

  logic           en;
  logic           modo;
  logic           wr_en;
  logic [WCH-1:0] wr_ch;
  logic [R-1:0]   wr_duty;
  logic [CH-1:0]  pwm_out;
  logic [R-1:0]   ciclo;
  logic           fin_periodo;

  modport master (
    output en, modo, wr_en, wr_ch, wr_duty,
    input  pwm_out, ciclo, fin_periodo
  );

  modport slave (
    input  en, modo, wr_en, wr_ch, wr_duty,
    output pwm_out, ciclo, fin_periodo
  );

endinterface

// File: rtl/pwm_base_tiempo.sv
// Shared PWM time base: prescaler, up/down period counter, direction and latched mode.
module pwm_base_tiempo
  import pwm_pkg::*;
#(
  parameter int R = 8,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         modo_i,
  output logic [R-1:0] ciclo_o,
  output logic         tick_o,
  output logic         boundary_o
);

  localparam int            PW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(N - 1);
  localparam logic [R-1:0]  C_MAX = {R{1'b1}};

  logic [PW-1:0] presc_q, presc_d;
  logic [R-1:0]  ciclo_q, ciclo_d;
  dir_e          dir_q, dir_d;
  logic          modo_act_q, modo_act_d;
  logic          tick_s;

  always_comb begin
    tick_s     = en_i && (presc_q == P_MAX);
    presc_d    = presc_q;
    ciclo_d    = ciclo_q;
    dir_d      = dir_q;
    modo_act_d = modo_act_q;
    if (!en_i) begin
      presc_d    = '0;
      ciclo_d    = '0;
      dir_d      = SUBE;
      modo_act_d = modo_i;
    end else if (tick_s) begin
      presc_d = '0;
      // Edge mode relies on the all-ones maximum wrapping to zero.
      case (modo_act_q)
        MODO_BORDE:  ciclo_d = ciclo_q + 1'b1;
        MODO_CENTRO: begin
          if ((dir_q == SUBE) && (ciclo_q != C_MAX)) begin
            ciclo_d = ciclo_q + 1'b1;
          end else begin
            ciclo_d = ciclo_q - 1'b1;
            dir_d   = BAJA;
          end
        end
        default:     ciclo_d = '0;
      endcase
      if (ciclo_d == '0) begin
        dir_d      = SUBE;
        modo_act_d = modo_i;
      end else begin
        modo_act_d = modo_act_q;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q    <= '0;
      ciclo_q    <= '0;
      dir_q      <= SUBE;
      modo_act_q <= MODO_BORDE;
    end else begin
      presc_q    <= presc_d;
      ciclo_q    <= ciclo_d;
      dir_q      <= dir_d;
      modo_act_q <= modo_act_d;
    end
  end

  assign ciclo_o    = ciclo_q;
  assign tick_o     = tick_s;
  assign boundary_o = tick_s && (ciclo_d == '0);

endmodule

// File: rtl/pwm_multicanal.sv
// Multi-channel PWM: one shared time base feeding CH double-buffered duty comparators.
module pwm_multicanal
  import pwm_pkg::*;
#(
  parameter int R  = 8,
  parameter int N  = 1,
  parameter int CH = 4
) (
  input  logic             clk,
  input  logic             reset,
  pwm_multicanal_if.slave  bus
);

  localparam int WCH = ancho_ch(CH);

  logic [R-1:0]  ciclo_s;
  logic          tick_s;
  logic          boundary_s;
  logic          carga_s;
  logic          fin_q;
  logic [CH-1:0] pwm_s;

  pwm_base_tiempo #(
    .R (R),
    .N (N)
  ) u_base (
    .clk        (clk),
    .reset      (reset),
    .en_i       (bus.en),
    .modo_i     (bus.modo),
    .ciclo_o    (ciclo_s),
    .tick_o     (tick_s),
    .boundary_o (boundary_s)
  );

  // While disabled the active duties follow the shadows so restart uses fresh values.
  assign carga_s = !bus.en || (tick_s && boundary_s);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fin_q <= 1'b0;
    end else begin
      fin_q <= boundary_s;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_canal
    logic [R-1:0] sombra_q;
    logic [R-1:0] act_q;
    logic         pwm_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        sombra_q <= '0;
        act_q    <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (bus.wr_en && (bus.wr_ch == WCH'(i))) begin
          sombra_q <= bus.wr_duty;
        end
        if (carga_s) begin
          act_q <= sombra_q;
        end
        pwm_q <= bus.en && (ciclo_s < act_q);
      end
    end

    assign pwm_s[i] = pwm_q;
  end

  assign bus.ciclo       = ciclo_s;
  assign bus.pwm_out     = pwm_s;
  assign bus.fin_periodo = fin_q;

endmodule

// File: tb/tb_pwm_multicanal.sv
// Scoreboard bench for pwm_multicanal: per-period length and high-time per channel.
module tb_pwm_multicanal;

  typedef int arr5_t [5];
  typedef struct {
    int    len;
    arr5_t hi;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   k_main;
  exp_t q_a[$];
  exp_t q_b[$];

  pwm_multicanal_if #(.R(4), .CH(4)) bus_a ();
  pwm_multicanal_if #(.R(4), .CH(5)) bus_b ();

  pwm_multicanal #(.R(4), .N(1), .CH(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  pwm_multicanal #(.R(4), .N(3), .CH(5)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int len, input int h0, input int h1, input int h2,
                              input int h3, input int h4);
    exp_t e;
    e.len = len;
    e.hi  = '{h0, h1, h2, h3, h4};
    return e;
  endfunction

  task automatic cmp_period(input string tag, input exp_t e, input int len, input arr5_t hi,
                            input int nch);
    chk({tag, "_len"}, len, e.len);
    for (int c = 0; c < nch; c++) chk($sformatf("%s_ch%0d_high", tag, c), hi[c], e.hi[c]);
  endtask

  // Monitor A: accumulate one period, compare on each fin_periodo after the first.
  int    len_a;
  arr5_t hi_a;
  bit    prev_a;
  exp_t  e_a;
  always @(negedge clk) begin
    if (!reset || !bus_a.en) begin
      prev_a = 1'b0; len_a = 0; hi_a = '{default: 0};
    end else begin
      len_a++;
      for (int c = 0; c < 4; c++) if (bus_a.pwm_out[c]) hi_a[c]++;
      if (bus_a.fin_periodo) begin
        if (prev_a) begin
          if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_a_unexpected: got period of %0d clk, expected none", len_a);
          end else begin
            e_a = q_a.pop_front();
            cmp_period("sb_a", e_a, len_a, hi_a, 4);
          end
        end
        prev_a = 1'b1; len_a = 0; hi_a = '{default: 0};
      end
    end
  end

  int    len_b;
  arr5_t hi_b;
  bit    prev_b;
  exp_t  e_b;
  always @(negedge clk) begin
    if (!reset || !bus_b.en) begin
      prev_b = 1'b0; len_b = 0; hi_b = '{default: 0};
    end else begin
      len_b++;
      for (int c = 0; c < 5; c++) if (bus_b.pwm_out[c]) hi_b[c]++;
      if (bus_b.fin_periodo) begin
        if (prev_b) begin
          if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_b_unexpected: got period of %0d clk, expected none", len_b);
          end else begin
            e_b = q_b.pop_front();
            cmp_period("sb_b", e_b, len_b, hi_b, 5);
          end
        end
        prev_b = 1'b1; len_b = 0; hi_b = '{default: 0};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input int ch, input int d);
    if (sel == 0) begin
      bus_a.wr_en = 1'b1; bus_a.wr_ch = ch[1:0]; bus_a.wr_duty = d[3:0];
    end else begin
      bus_b.wr_en = 1'b1; bus_b.wr_ch = ch[2:0]; bus_b.wr_duty = d[3:0];
    end
    step();
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
  endtask

  // Counts clock edges until fin_periodo is seen, then moves just past the next edge.
  task automatic wait_fin(input int sel, input int lim, output int k);
    logic f;
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
      f = (sel == 0) ? bus_a.fin_periodo : bus_b.fin_periodo;
    end while (!f && k < lim);
    checks++;
    if (!f) begin
      errors++;
      $display("FAIL wait_fin_%0d: got no fin_periodo, expected one within %0d clk", sel, lim);
    end
    step();
  endtask

  task automatic wait_ciclo(input int sel, input int v);
    int n;
    int c;
    n = 0;
    c = (sel == 0) ? int'(bus_a.ciclo) : int'(bus_b.ciclo);
    while (c != v && n < 200) begin
      step();
      n++;
      c = (sel == 0) ? int'(bus_a.ciclo) : int'(bus_b.ciclo);
    end
    checks++;
    if (c != v) begin
      errors++;
      $display("FAIL wait_ciclo_%0d: got ciclo %0d, expected %0d", sel, c, v);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus_a.en = 1'b1; bus_a.modo = 1'b0; bus_a.wr_en = 1'b1; bus_a.wr_ch = 2'd0; bus_a.wr_duty = 4'd9;
    bus_b.en = 1'b0; bus_b.modo = 1'b0; bus_b.wr_en = 1'b0; bus_b.wr_ch = 3'd0; bus_b.wr_duty = 4'd0;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_pwm", bus_a.pwm_out, 0);
      chk("rst_ciclo", bus_a.ciclo, 0);
      chk("rst_fin", bus_a.fin_periodo, 0);
    end
    step();
    reset = 1'b1; bus_a.en = 1'b0; bus_a.wr_en = 1'b0;

    // Edge mode; ch0 left unwritten so a reset-time write would show up as ch0 high time.
    wr(0, 1, 0); wr(0, 2, 15); wr(0, 3, 8);
    q_a.push_back(mk(16, 0, 0, 15, 8, 0));
    bus_a.en = 1'b1;
    wait_fin(0, 40, k_main);
    chk("first_fin_delay_a", k_main, 16);

    q_a.push_back(mk(16, 4, 0, 15, 8, 0));
    wr(0, 0, 4);
    wait_fin(0, 40, k_main);

    // Mid-period write at ciclo=7 waits for the next boundary.
    q_a.push_back(mk(16, 12, 0, 15, 8, 0));
    wait_ciclo(0, 7);
    wr(0, 0, 12);
    wait_fin(0, 40, k_main);

    // Write landing on the boundary edge shows up one period later.
    q_a.push_back(mk(16, 12, 0, 15, 8, 0));
    q_a.push_back(mk(16, 2, 0, 15, 8, 0));
    wait_ciclo(0, 15);
    wr(0, 0, 2);
    wait_fin(0, 40, k_main);

    wait_ciclo(0, 8);
    @(negedge clk);
    chk("lag_ch3_at8", bus_a.pwm_out[3], 1);
    @(negedge clk);
    chk("lag_ch3_at9", bus_a.pwm_out[3], 0);
    chk("lag_ch2_at9", bus_a.pwm_out[2], 1);
    step();

    // Center mode period: 30 clk, D=5 -> 9 high, D=15 -> 29 high.
    q_a.push_back(mk(30, 9, 0, 29, 29, 0));
    wr(0, 0, 5); wr(0, 3, 15);
    bus_a.modo = 1'b1;
    wait_fin(0, 40, k_main);
    bus_a.modo = 1'b0;
    wait_fin(0, 40, k_main);

    wait_ciclo(0, 9);
    bus_a.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("dis_ciclo", bus_a.ciclo, 0);
    chk("dis_pwm", bus_a.pwm_out, 0);
    chk("dis_fin", bus_a.fin_periodo, 0);
    step(); step();
    bus_a.en = 1'b1;
    wait_fin(0, 40, k_main);
    chk("reen_fin_delay_a", k_main, 16);
    q_a.push_back(mk(16, 5, 0, 15, 15, 0));
    wait_fin(0, 40, k_main);
    bus_a.en = 1'b0;

    // Prescaler N=3, CH=5: out-of-range channel writes must be dropped.
    wr(1, 4, 7); wr(1, 5, 9); wr(1, 7, 11);
    q_b.push_back(mk(48, 0, 0, 0, 0, 21));
    bus_b.en = 1'b1;
    wait_fin(1, 100, k_main);
    chk("first_fin_delay_b", k_main, 48);
    @(negedge clk);
    chk("b_fin_width", bus_b.fin_periodo, 0);
    chk("b_hold0", bus_b.ciclo, 0);
    @(negedge clk);
    chk("b_hold1", bus_b.ciclo, 0);
    @(negedge clk);
    chk("b_hold2", bus_b.ciclo, 1);
    wait_fin(1, 100, k_main);
    bus_b.en = 1'b0;

    repeat (3) step();
    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
